// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the instruction-fetch path
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_MAR = 3'd0,
    ST_READ     = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_FAULT    = 3'd4
  } fetch_state_e;

  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 26;
  localparam logic [31:0] PC_STEP    = 32'd4;

  function automatic logic pc_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multicycle fetch FSM owning PC, MAR and IR
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MOC_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_moc,
  input  logic        exec_done,
  input  logic        pc_load,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic        inst_valid,
  output logic        fault
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MOC_TIMEOUT);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  mar_q, mar_d;
  logic [31:0]  ir_q, ir_d;
  logic [7:0]   wait_q, wait_d;
  logic [7:0]   wait_inc;

  assign wait_inc = wait_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD_MAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD_MAR: state_d = pc_aligned(pc_q) ? ST_READ : ST_FAULT;
      ST_READ: begin
        if (mem_moc) begin
          state_d = ST_DECODE;
        end else if (wait_inc == TIMEOUT_CNT) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE:   state_d = ST_EXEC;
      ST_EXEC:     if (exec_done) state_d = ST_LOAD_MAR;
      ST_FAULT:    state_d = ST_FAULT;
      default:     state_d = ST_FAULT;
    endcase
  end

  // Wait counter is zero everywhere outside READ, so it is already clear on entry.
  always_comb begin
    pc_d   = pc_q;
    mar_d  = mar_q;
    ir_d   = ir_q;
    wait_d = 8'd0;
    case (state_q)
      ST_LOAD_MAR: mar_d = pc_q;
      ST_READ: begin
        if (mem_moc) begin
          ir_d = mem_rdata;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_DECODE:   pc_d = pc_q + PC_STEP;
      ST_EXEC:     if (exec_done && pc_load) pc_d = next_pc;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      mar_q  <= 32'd0;
      ir_q   <= 32'd0;
      wait_q <= 8'd0;
    end else begin
      pc_q   <= pc_d;
      mar_q  <= mar_d;
      ir_q   <= ir_d;
      wait_q <= wait_d;
    end
  end

  always_comb begin
    mem_rd     = (state_q == ST_READ);
    inst_valid = (state_q == ST_DECODE);
    fault      = (state_q == ST_FAULT);
  end

  assign mem_addr = mar_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign opcode   = ir_q[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_moc;
  logic        exec_done;
  logic        pc_load;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic        inst_valid;
  logic        fault;

  fetch_sequencer #(.RESET_PC(RESET_PC), .MOC_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_moc(mem_moc), .exec_done(exec_done),
    .pc_load(pc_load), .next_pc(next_pc), .pc(pc), .ir(ir), .opcode(opcode),
    .inst_valid(inst_valid), .fault(fault)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } fetch_t;

  fetch_t sb[$];
  int checks   = 0;
  int failures = 0;
  int moc_delay = 0;
  int rd_cnt    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h2008_0005;
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: data follows MAR, completion after moc_delay READ cycles.
  initial begin
    mem_rdata = 32'd0;
    mem_moc   = 1'b0;
    forever begin
      @(negedge clk);
      mem_rdata = mem_word(mem_addr);
      if (mem_rd) begin
        mem_moc = (rd_cnt == moc_delay);
        rd_cnt++;
      end else begin
        mem_moc = 1'b0;
        rd_cnt  = 0;
      end
    end
  end

  // Scoreboard monitor: pop on every inst_valid, check PC+4 on the following cycle.
  initial begin
    fetch_t      e;
    logic        pend = 1'b0;
    logic [31:0] exp_pc = 32'd0;
    forever begin
      @(negedge clk);
      if (pend && !reset) check("pc_after_decode", pc, exp_pc);
      pend = 1'b0;
      if (inst_valid) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_valid", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("sb_mem_addr", mem_addr, e.addr);
          check("sb_ir", ir, e.word);
          check("sb_opcode", {26'd0, opcode}, {26'd0, e.word[31:26]});
          check("sb_pc_in_decode", pc, e.addr);
          exp_pc = e.addr + 32'd4;
          pend   = 1'b1;
        end
      end
    end
  end

  task automatic push_fetch(input logic [31:0] a);
    fetch_t e;
    e.addr = a;
    e.word = mem_word(a);
    sb.push_back(e);
  endtask

  // Call at a LOAD_MAR negedge; returns at the DECODE negedge.
  task automatic fetch_from_load(input string tag, input int exp_n, input int exp_rd);
    int n  = 0;
    int rd = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_rd) rd++;
    end while (!inst_valid && n < 60);
    check({tag, "_latency"}, 32'(n), 32'(exp_n));
    check({tag, "_rd_cycles"}, 32'(rd), 32'(exp_rd));
    check({tag, "_no_fault"}, {31'd0, fault}, 32'd0);
  endtask

  // Call at a DECODE negedge; returns at the following LOAD_MAR negedge.
  task automatic finish_exec(input logic load, input logic [31:0] target);
    @(negedge clk);
    exec_done = 1'b1;
    pc_load   = load;
    next_pc   = target;
    @(negedge clk);
    exec_done = 1'b0;
    pc_load   = 1'b0;
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    exec_done = 1'b0;
    pc_load   = 1'b0;
    next_pc   = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, RESET_PC);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);

    // Back-to-back fetch with moc and exec_done high.
    push_fetch(32'd0);
    push_fetch(32'd4);
    moc_delay = 0;
    exec_done = 1'b1;
    reset     = 1'b0;
    fetch_from_load("first", 2, 1);
    check("first_opcode", {26'd0, opcode}, {26'd0, 6'b001000});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inst_valid && n < 20);
    exec_done = 1'b0;
    check("throughput_gap", 32'(n), 32'd4);

    // Delayed memory completion.
    push_fetch(32'd8);
    moc_delay = 5;
    finish_exec(1'b0, 32'd0);
    fetch_from_load("delay5", 7, 6);

    // Redirect to aligned target.
    push_fetch(32'h40);
    moc_delay = 0;
    finish_exec(1'b1, 32'h40);
    fetch_from_load("redirect", 2, 1);

    // PC wrap at the top of the address space.
    push_fetch(32'hFFFF_FFFC);
    finish_exec(1'b1, 32'hFFFF_FFFC);
    fetch_from_load("wrap", 2, 1);
    @(negedge clk);
    check("wrap_pc_zero", pc, 32'd0);

    // Misaligned redirect faults at LOAD_MAR.
    exec_done = 1'b1;
    pc_load   = 1'b1;
    next_pc   = 32'h42;
    @(negedge clk);
    exec_done = 1'b0;
    pc_load   = 1'b0;
    @(negedge clk);
    check("misalign_fault", {31'd0, fault}, 32'd1);
    repeat (3) @(negedge clk);
    check("misalign_fault_sticky", {31'd0, fault}, 32'd1);
    check("misalign_no_rd", {31'd0, mem_rd}, 32'd0);

    reset = 1'b1;
    @(negedge clk);
    check("recover1_pc", pc, RESET_PC);
    check("recover1_fault", {31'd0, fault}, 32'd0);

    // Memory never completes: timeout after 15 READ cycles.
    moc_delay = 255;
    reset = 1'b0;
    n = 0;
    begin
      int budget = 0;
      do begin
        @(negedge clk);
        budget++;
        if (mem_rd) n++;
      end while (!fault && budget < 100);
    end
    check("timeout_rd_cycles", 32'(n), 32'd15);
    check("timeout_fault", {31'd0, fault}, 32'd1);
    repeat (2) @(negedge clk);
    check("timeout_no_rd", {31'd0, mem_rd}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("recover2_pc", pc, RESET_PC);
    check("recover2_fault", {31'd0, fault}, 32'd0);

    // Reset wins over a completion arriving in the same cycle.
    moc_delay = 2;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midread_moc_seen", {31'd0, mem_moc}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midread_ir", ir, 32'd0);
    check("midread_pc", pc, RESET_PC);
    check("midread_mem_rd", {31'd0, mem_rd}, 32'd0);
    push_fetch(RESET_PC);
    moc_delay = 0;
    reset = 1'b0;
    fetch_from_load("after_midread", 2, 1);
    repeat (3) @(negedge clk);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
